// File: rtl/array_word_serializer.sv
// array_word_serializer
//   Captures a whole flattened word array (a "frame") in one valid/ready
//   handshake. It then replays the frame one word per beat on a valid/ready
//   output stream. Each beat carries its word index, a last flag and even
//   parity. A wrapping counter records how many frames were fully emitted.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   in_valid        frame offered on in_data
//   in_ready        frame can be taken this cycle (combinational in STREAM)
//   in_data         N*W bits; word k = in_data[k*W +: W], word 0 sent first
//   out_valid       beat valid (registered)
//   out_ready       downstream accepts the beat
//   out_data        current word
//   out_idx         index of the current word
//   out_last        current word is the final one of the frame
//   out_parity      XOR of all bits of out_data
//   frame_cnt       frames fully emitted, wraps to 0
module array_word_serializer #(
  parameter int W     = 64,
  parameter int ROWS  = 2,
  parameter int COLS  = 3,
  parameter int CNT_W = 16,
  localparam int N     = ROWS * COLS,
  localparam int IDX_W = $clog2(N) | 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*W-1:0]     in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out_data,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_last,
  output logic               out_parity,
  output logic [CNT_W-1:0]   frame_cnt
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t           state_r;
  logic             ready_en_r;   // holds in_ready low until the first edge after reset
  logic [W-1:0]     buf_r [N];
  logic             in_ready_s;
  logic             load_s;
  logic             adv_s;
  logic             done_s;
  logic [IDX_W-1:0] nidx_s;
  logic [W-1:0]     nword_s;

  function automatic logic even_parity(input logic [W-1:0] word);
    return ^word;
  endfunction

  // Input acceptance: open in IDLE, and in STREAM only while the last beat leaves.
  always_comb begin
    in_ready_s = 1'b0;
    if (!ready_en_r) begin
      in_ready_s = 1'b0;
    end else begin
      case (state_r)
        IDLE:    in_ready_s = 1'b1;
        STREAM:  in_ready_s = out_ready & out_last;
        default: in_ready_s = 1'b0;
      endcase
    end
  end

  assign in_ready = in_ready_s;

  // Classify this cycle: new frame load, mid-frame advance, or final beat without reload.
  always_comb begin
    load_s = in_valid & in_ready_s;
    adv_s  = 1'b0;
    done_s = 1'b0;
    if ((state_r == STREAM) && out_valid && out_ready) begin
      adv_s  = ~out_last;
      done_s = out_last;
    end else begin
      adv_s  = 1'b0;
      done_s = 1'b0;
    end
  end

  // Select the buffered word that follows the current one.
  always_comb begin
    nidx_s  = out_idx + IDX_W'(1);
    nword_s = '0;
    for (int k = 0; k < N; k++) begin
      nword_s = (nidx_s == IDX_W'(k)) ? buf_r[k] : nword_s;
    end
  end

  // Frame buffer, state and registered output beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      ready_en_r <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_idx    <= '0;
      out_last   <= 1'b0;
      out_parity <= 1'b0;
      for (int k = 0; k < N; k++) begin
        buf_r[k] <= '0;
      end
    end else begin
      ready_en_r <= 1'b1;
      if (load_s) begin
        // A reload on the last beat lands here too, so back-to-back frames have no bubble.
        for (int k = 0; k < N; k++) begin
          buf_r[k] <= in_data[k*W +: W];
        end
        state_r    <= STREAM;
        out_valid  <= 1'b1;
        out_data   <= in_data[W-1:0];
        out_idx    <= '0;
        out_last   <= (N == 1) ? 1'b1 : 1'b0;
        out_parity <= even_parity(in_data[W-1:0]);
      end else if (adv_s) begin
        out_data   <= nword_s;
        out_idx    <= nidx_s;
        out_last   <= (nidx_s == IDX_W'(N - 1)) ? 1'b1 : 1'b0;
        out_parity <= even_parity(nword_s);
      end else if (done_s) begin
        state_r   <= IDLE;
        out_valid <= 1'b0;
      end else begin
        // Stalled or idle: every output holds.
        state_r <= state_r;
      end
    end
  end

  // Completed-frame counter, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (done_s || (load_s && (state_r == STREAM))) begin
      frame_cnt <= frame_cnt + CNT_W'(1);
    end else begin
      frame_cnt <= frame_cnt;
    end
  end

endmodule

// File: tb/tb_array_word_serializer.sv
// tb_array_word_serializer
//   Scoreboard bench for array_word_serializer.
//   - Accepted frames are expanded into expected beats and queued.
//   - A negedge monitor pops and compares every beat the DUT hands over.
//   - A second, small instance (N=1, CNT_W=2) checks single-word frames and
//     counter wrap.
module tb_array_word_serializer;

  localparam int W     = 64;
  localparam int N     = 6;
  localparam int IDX_W = 3;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [N*W-1:0]   in_data;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             out_parity;
  logic [CNT_W-1:0] frame_cnt;

  logic       in_valid2;
  logic       in_ready2;
  logic [7:0] in_data2;
  logic       out_valid2;
  logic [7:0] out_data2;
  logic [0:0] out_idx2;
  logic       out_last2;
  logic       out_parity2;
  logic [1:0] frame_cnt2;

  array_word_serializer #(.W(W), .ROWS(2), .COLS(3), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
    .out_parity(out_parity), .frame_cnt(frame_cnt)
  );

  array_word_serializer #(.W(8), .ROWS(1), .COLS(1), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data2), .out_valid(out_valid2), .out_ready(1'b1),
    .out_data(out_data2), .out_idx(out_idx2), .out_last(out_last2),
    .out_parity(out_parity2), .frame_cnt(frame_cnt2)
  );

  typedef struct {
    logic [63:0] data;
    int          idx;
    bit          last;
    bit          par;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    exp_cnt = 0;
  int    mode = 0;          // 0: always ready, 1: random, 2: stall 3 cycles at idx 1
  int    stall_left = 0;
  int    stall_seen = 0;
  int    run_len = 0;
  int    max_run = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a frame is N words, sent in order, last on the final one.
  function automatic void push_frame(input logic [N*W-1:0] f);
    beat_t b;
    for (int k = 0; k < N; k++) begin
      b.data = f[k*W +: W];
      b.idx  = k;
      b.last = (k == N - 1);
      b.par  = ^b.data;
      exp_q.push_back(b);
    end
  endfunction

  // Monitor: compare each handed-over beat and check stability through stalls.
  initial begin
    bit          prev_stall;
    logic [63:0] pd;
    int          pi;
    bit          pl, pp;
    beat_t       b;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        run_len = 0;
      end else begin
        chk("frame_cnt", 64'(frame_cnt), 64'(exp_cnt));
        if (prev_stall) begin
          chk("stall_valid", 64'(out_valid), 64'd1);
          chk("stall_data", out_data, pd);
          chk("stall_idx", 64'(out_idx), 64'(pi));
          chk("stall_last", 64'(out_last), 64'(pl));
          chk("stall_parity", 64'(out_parity), 64'(pp));
        end
        if (out_valid) begin
          run_len++;
          if (run_len > max_run) max_run = run_len;
        end else begin
          run_len = 0;
        end
        if (out_valid && out_ready) begin
          prev_stall = 1'b0;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: got data %0h idx %0d, expected no beat", out_data, out_idx);
          end else begin
            b = exp_q.pop_front();
            chk("beat_data", out_data, b.data);
            chk("beat_idx", 64'(out_idx), 64'(b.idx));
            chk("beat_last", 64'(out_last), 64'(b.last));
            chk("beat_parity", 64'(out_parity), 64'(b.par));
            if (b.last) exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
          end
        end else if (out_valid) begin
          prev_stall = 1'b1;
          stall_seen++;
          pd = out_data;
          pi = int'(out_idx);
          pl = out_last;
          pp = out_parity;
        end else begin
          prev_stall = 1'b0;
        end
      end
    end
  end

  // Downstream ready generator.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (stall_left > 0 && out_valid && out_idx == 3'd1) begin
            out_ready = 1'b0;
            stall_left--;
          end else begin
            out_ready = 1'b1;
          end
        end
        default: out_ready = 1'b1;
      endcase
    end
  end

  task automatic send_frame(input logic [N*W-1:0] f);
    bit acc;
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = f;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        push_frame(f);
        ok = 1'b1;
        break;
      end
    end
    in_data = '1;  // later changes must not affect the captured frame
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout: got no handshake, expected accept within 300 cycles");
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drain_timeout: got %0d beats pending, expected 0", exp_q.size());
    end
  endtask

  function automatic logic [N*W-1:0] rand_frame();
    logic [N*W-1:0] f;
    for (int k = 0; k < N; k++) begin
      f[k*W +: W] = {$urandom, $urandom};
    end
    return f;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected completion before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*W-1:0] f1;
    logic [N*W-1:0] fa;
    logic [7:0]     d [5];
    bit             hit;

    f1 = {64'h0, 64'h1, 64'h5, 64'h1E, 64'h3, 64'h2};
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_valid2 = 1'b0;
    in_data2 = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_idx", 64'(out_idx), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_out_parity", 64'(out_parity), 64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("ready_after_edge", 64'(in_ready), 64'd1);

    // Directed frame, no back-pressure.
    mode = 0;
    max_run = 0;
    send_frame(f1);
    in_valid = 1'b0;
    drain();
    chk("t1_frame_cnt", 64'(frame_cnt), 64'd1);
    chk("t1_idle_valid", 64'(out_valid), 64'd0);
    chk("t1_idle_ready", 64'(in_ready), 64'd1);
    chk("t1_run_len", 64'(max_run), 64'd6);

    // Same frame, stalled for 3 cycles on idx 1.
    mode = 2;
    stall_left = 3;
    stall_seen = 0;
    send_frame(f1);
    in_valid = 1'b0;
    drain();
    chk("t2_stall_cycles", 64'(stall_seen), 64'd3);
    chk("t2_frame_cnt", 64'(frame_cnt), 64'd2);

    // Two frames back to back with in_valid held high.
    mode = 0;
    max_run = 0;
    send_frame(rand_frame());
    send_frame(rand_frame());
    in_valid = 1'b0;
    drain();
    chk("t3_run_len", 64'(max_run), 64'd12);
    chk("t3_frame_cnt", 64'(frame_cnt), 64'd4);

    // Reset while idx 3 is on the output.
    send_frame(f1);
    in_valid = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (out_valid && out_idx == 3'd3) begin
        hit = 1'b1;
        break;
      end
    end
    chk("t5_reached_idx3", 64'(hit), 64'd1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    exp_cnt = 0;
    #1;
    chk("t5_async_valid", 64'(out_valid), 64'd0);
    chk("t5_async_cnt", 64'(frame_cnt), 64'd0);
    chk("t5_async_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_ready_after", 64'(in_ready), 64'd1);
    send_frame(rand_frame());
    in_valid = 1'b0;
    drain();
    chk("t5_frame_cnt", 64'(frame_cnt), 64'd1);

    // Randomized frames with random back-pressure and input gaps.
    mode = 1;
    for (int i = 0; i < 25; i++) begin
      fa = rand_frame();
      if (i % 5 == 0) fa[W-1:0] = 64'd0;
      send_frame(fa);
      if ($urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
    mode = 0;
    drain();
    chk("rand_frame_cnt", 64'(frame_cnt), 64'd26);

    // N=1, CNT_W=2: one beat per cycle and counter wrap 1,2,3,0,1.
    for (int k = 0; k < 5; k++) d[k] = 8'($urandom);
    @(posedge clk);
    #1;
    in_valid2 = 1'b1;
    in_data2 = d[0];
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      if (k < 5) in_data2 = d[k];
      else in_valid2 = 1'b0;
      @(negedge clk);
      if (k <= 5) begin
        chk("n1_valid", 64'(out_valid2), 64'd1);
        chk("n1_data", 64'(out_data2), 64'(d[k-1]));
        chk("n1_idx", 64'(out_idx2), 64'd0);
        chk("n1_last", 64'(out_last2), 64'd1);
        chk("n1_parity", 64'(out_parity2), 64'(^d[k-1]));
      end else begin
        chk("n1_idle", 64'(out_valid2), 64'd0);
      end
      chk("n1_frame_cnt", 64'(frame_cnt2), 64'((k - 1) % 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
